key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 The module SHALL have parameter LONG_CYC, default 50000000, meaning the number of cycles a first press must last to count as a long press (legal values >= 2).
REQ-002 The module SHALL have parameter GAP_CYC, default 25000000, meaning the maximum number of released cycles allowed between the two presses of a double click (legal values >= 2).
REQ-003 The module SHALL have parameter RPT_CYC, default 10000000, meaning the auto-repeat period while a long press is held (legal values >= 2).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port key_in, input, 1 bit: already-debounced key level from the upstream debounce stage, 1 = pressed.
REQ-007 The module SHALL have port evt_single, output, 1 bit: one-cycle pulse on a single click.
REQ-008 The module SHALL have port evt_double, output, 1 bit: one-cycle pulse on a double click.
REQ-009 The module SHALL have port evt_long, output, 1 bit: one-cycle pulse when a long press is recognised.
REQ-010 The module SHALL have port evt_rpt, output, 1 bit: one-cycle auto-repeat pulse during a long press.
REQ-011 The module SHALL have port evt_hold, output, 1 bit: level, high while in state LONG.
REQ-012 The module SHALL have port busy, output, 1 bit: level, high when the state is not IDLE.

Function
REQ-013 All outputs SHALL be registered, and each evt_* pulse SHALL be high for exactly one cycle, starting at the clock edge that samples its trigger condition.
REQ-014 The FSM SHALL have states ARM, IDLE, PRESS1, WAIT2, PRESS2 and LONG, plus one 32-bit counter cnt that clears to 0 on every state entry and increments every cycle otherwise, unless a rule below says differently.
REQ-015 In ARM, key_in=0 SHALL move the FSM to IDLE; key_in=1 SHALL keep it in ARM, and no event SHALL be emitted from ARM.
REQ-016 In IDLE, key_in=1 SHALL move the FSM to PRESS1.
REQ-017 In PRESS1, key_in=0 SHALL move the FSM to WAIT2; otherwise, key_in=1 with cnt==LONG_CYC-1 SHALL move it to LONG and pulse evt_long.
REQ-018 In WAIT2, key_in=1 SHALL move the FSM to PRESS2; otherwise, cnt==GAP_CYC-1 SHALL move it to IDLE and pulse evt_single.
REQ-019 In PRESS2, key_in=0 SHALL move the FSM to IDLE and pulse evt_double; a second press has no long detection, and its counter SHALL saturate rather than wrap.
REQ-020 In LONG, key_in=0 SHALL move the FSM to IDLE with no event; otherwise, cnt==RPT_CYC-1 SHALL pulse evt_rpt and reset cnt to 0 while the FSM stays in LONG.
REQ-021 Release has priority over a simultaneous counter terminal value in every state.
REQ-022 A press held for exactly LONG_CYC sampled cycles and then released SHALL be classified as a click, not a long press.
REQ-023 At most one evt_* output SHALL be high in any cycle.
REQ-024 evt_hold SHALL be 1 exactly in the cycles where the state is LONG, including the evt_long cycle.
REQ-025 busy SHALL be 1 in states ARM, PRESS1, WAIT2, PRESS2 and LONG.
REQ-026 Parameters outside their legal range are unsupported; no checking is required.

Reset
REQ-027 rst_n=0 SHALL immediately force state=ARM, cnt=0, all evt_* outputs and evt_hold=0, and busy=1, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard any pending classification, with no event emitted before or after reset.
REQ-029 After rst_n is released, a key that is still held SHALL produce no event until it has been observed released (the ARM rule).

Verification (LONG_CYC=20, GAP_CYC=10, RPT_CYC=5)
REQ-030 Key high 5 cycles, then low -> evt_single at the 10th edge after the release-sampling edge; no other events; busy drops with it.
REQ-031 Key high 5, low 4, high 5, low -> one evt_double at the edge sampling the second release; evt_single never fires.
REQ-032 Key high 32 sampled cycles -> evt_long at the 20th edge after the press-sampling edge, evt_rpt 5 and 10 edges later, evt_hold high from evt_long until release, no click event.
REQ-033 Key high exactly 20 sampled cycles, then low for 12 -> evt_single and no evt_long; key high 21 cycles -> evt_long and no evt_single.
REQ-034 Key held, rst_n pulsed low mid-PRESS1 and released with key still high for 30 cycles -> no events, busy=1; after release and a new 5-cycle press -> evt_single as in REQ-030.
REQ-035 Key low 9 cycles between presses -> double click; key low 10 cycles -> evt_single, then the second press starts a new sequence from IDLE.

Source files
------------

// File: rtl/key_event_decoder.sv
// Classifies a debounced key into single click, double click, long press and
// auto-repeat events; all outputs are registered one-cycle pulses or levels.
module key_event_decoder #(
   parameter int unsigned LONG_CYC = 50000000,
   parameter int unsigned GAP_CYC  = 25000000,
   parameter int unsigned RPT_CYC  = 10000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic evt_single,
   output logic evt_double,
   output logic evt_long,
   output logic evt_rpt,
   output logic evt_hold,
   output logic busy
);

   typedef enum logic [2:0] {
      ARM    = 3'd0,
      IDLE   = 3'd1,
      PRESS1 = 3'd2,
      WAIT2  = 3'd3,
      PRESS2 = 3'd4,
      LONG   = 3'd5
   } state_t;

   localparam logic [31:0] LONG_LAST = 32'(LONG_CYC - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
   localparam logic [31:0] RPT_LAST  = 32'(RPT_CYC - 1);

   state_t      state;
   logic [31:0] cnt;

   // NOTE: every register here is assigned with <= so all updates see the
   // pre-edge values of state and cnt, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARM;
         cnt        <= '0;
         evt_single <= 1'b0;
         evt_double <= 1'b0;
         evt_long   <= 1'b0;
         evt_rpt    <= 1'b0;
         evt_hold   <= 1'b0;
         busy       <= 1'b1;
      end else begin
         evt_single <= 1'b0;
         evt_double <= 1'b0;
         evt_long   <= 1'b0;
         evt_rpt    <= 1'b0;

         unique case (state)
            ARM: begin
               // A key still held after reset must be seen released first.
               if (!key_in) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            IDLE: begin
               if (key_in) begin
                  state <= PRESS1;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            PRESS1: begin
               if (!key_in) begin
                  state <= WAIT2;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST) begin
                  state    <= LONG;
                  cnt      <= '0;
                  evt_long <= 1'b1;
                  evt_hold <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            WAIT2: begin
               if (key_in) begin
                  state <= PRESS2;
                  cnt   <= '0;
               end else if (cnt == GAP_LAST) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  evt_single <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            PRESS2: begin
               if (!key_in) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  evt_double <= 1'b1;
                  busy       <= 1'b0;
               end else if (cnt != '1) begin
                  cnt <= cnt + 32'd1;
               end
            end

            LONG: begin
               if (!key_in) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  evt_hold <= 1'b0;
                  busy     <= 1'b0;
               end else if (cnt == RPT_LAST) begin
                  cnt     <= '0;
                  evt_rpt <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            default: begin
               state    <= ARM;
               cnt      <= '0;
               evt_hold <= 1'b0;
               busy     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short timing parameters; each
// scenario records event counts and edge numbers and compares them to hand values.
module tb_key_event_decoder;

   localparam int unsigned LONG_CYC = 20;
   localparam int unsigned GAP_CYC  = 10;
   localparam int unsigned RPT_CYC  = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic key_in;
   logic evt_single, evt_double, evt_long, evt_rpt, evt_hold, busy;

   always #5 clk = ~clk;

   key_event_decoder #(
      .LONG_CYC (LONG_CYC),
      .GAP_CYC  (GAP_CYC),
      .RPT_CYC  (RPT_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in),
      .evt_single (evt_single),
      .evt_double (evt_double),
      .evt_long   (evt_long),
      .evt_rpt    (evt_rpt),
      .evt_hold   (evt_hold),
      .busy       (busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   int edge_no, n_multi;
   int n_single, n_double, n_long, n_rpt, n_hold;
   int e_single, e_double, e_long, rpt_first, rpt_last, hold_first, e_busy_fall;
   logic prev_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear();
      edge_no = 0;
      n_single = 0; n_double = 0; n_long = 0; n_rpt = 0; n_hold = 0;
      e_single = 0; e_double = 0; e_long = 0;
      rpt_first = 0; rpt_last = 0; hold_first = 0; e_busy_fall = 0;
      prev_busy = busy;
   endtask

   // Drive one key level, let one rising edge sample it, then observe outputs.
   task automatic cycle(input logic k);
      key_in = k;
      @(posedge clk);
      #1;
      edge_no++;
      if (evt_single) begin n_single++; e_single = edge_no; end
      if (evt_double) begin n_double++; e_double = edge_no; end
      if (evt_long)   begin n_long++;   e_long   = edge_no; end
      if (evt_rpt) begin
         if (n_rpt == 0) rpt_first = edge_no;
         n_rpt++;
         rpt_last = edge_no;
      end
      if (evt_hold) begin
         if (n_hold == 0) hold_first = edge_no;
         n_hold++;
      end
      if (int'(evt_single) + int'(evt_double) + int'(evt_long) + int'(evt_rpt) > 1)
         n_multi++;
      if (prev_busy && !busy) e_busy_fall = edge_no;
      prev_busy = busy;
   endtask

   task automatic drive(input logic k, input int n);
      for (int i = 0; i < n; i++) cycle(k);
   endtask

   initial begin
      n_multi = 0;
      key_in  = 1'b0;
      rst_n   = 1'b0;
      #12;
      check("reset_busy", 32'(busy), 32'd1);
      check("reset_evts", 32'({evt_single, evt_double, evt_long, evt_rpt, evt_hold}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clear();
      cycle(1'b0);
      check("arm_to_idle_busy", 32'(busy), 32'd0);
      drive(1'b0, 2);

      // Single click: press edges 1..5, release sampled at 6, single at 16.
      clear();
      drive(1'b1, 5);
      drive(1'b0, 14);
      check("single_count", 32'(n_single), 32'd1);
      check("single_edge", 32'(e_single), 32'd16);
      check("single_busy_fall", 32'(e_busy_fall), 32'd16);
      check("single_others", 32'(n_double + n_long + n_rpt + n_hold), 32'd0);

      // Double click: second release sampled at edge 15.
      clear();
      drive(1'b1, 5);
      drive(1'b0, 4);
      drive(1'b1, 5);
      drive(1'b0, 12);
      check("double_count", 32'(n_double), 32'd1);
      check("double_edge", 32'(e_double), 32'd15);
      check("double_no_single", 32'(n_single), 32'd0);

      // Long press held 32 edges: long at 21, repeats at 26 and 31, release at 33.
      clear();
      drive(1'b1, 32);
      drive(1'b0, 5);
      check("long_count", 32'(n_long), 32'd1);
      check("long_edge", 32'(e_long), 32'd21);
      check("rpt_count", 32'(n_rpt), 32'd2);
      check("rpt_first", 32'(rpt_first), 32'd26);
      check("rpt_last", 32'(rpt_last), 32'd31);
      check("hold_first", 32'(hold_first), 32'd21);
      check("hold_cycles", 32'(n_hold), 32'd12);
      check("long_no_click", 32'(n_single + n_double), 32'd0);
      check("long_busy_fall", 32'(e_busy_fall), 32'd33);

      // Exactly LONG_CYC sampled press cycles is still a click.
      clear();
      drive(1'b1, 20);
      drive(1'b0, 12);
      check("edge20_single_edge", 32'(e_single), 32'd31);
      check("edge20_counts", 32'({n_single[7:0], n_long[7:0]}), 32'h0100);

      // One more cycle turns it into a long press.
      clear();
      drive(1'b1, 21);
      drive(1'b0, 12);
      check("edge21_long_edge", 32'(e_long), 32'd21);
      check("edge21_counts", 32'({n_long[7:0], n_single[7:0], n_rpt[7:0]}), 32'h010000);

      // Gap of 9 released cycles still yields a double click.
      clear();
      drive(1'b1, 5);
      drive(1'b0, 9);
      drive(1'b1, 5);
      drive(1'b0, 12);
      check("gap9_double_edge", 32'(e_double), 32'd20);
      check("gap9_counts", 32'({n_double[7:0], n_single[7:0]}), 32'h0100);

      // Gap long enough to time out: single at 16, second press is a new single.
      clear();
      drive(1'b1, 5);
      drive(1'b0, 11);
      check("gap11_first_single", 32'(e_single), 32'd16);
      drive(1'b1, 5);
      drive(1'b0, 14);
      check("gap11_single_count", 32'(n_single), 32'd2);
      check("gap11_second_single", 32'(e_single), 32'd32);
      check("gap11_no_double", 32'(n_double), 32'd0);

      // Reset in the middle of PRESS1 with the key held throughout.
      clear();
      drive(1'b1, 8);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd1);
      check("midrst_evts", 32'({evt_single, evt_double, evt_long, evt_rpt, evt_hold}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 30);
      check("midrst_no_events", 32'(n_single + n_double + n_long + n_rpt + n_hold), 32'd0);
      check("midrst_busy_held", 32'(busy), 32'd1);
      drive(1'b0, 3);
      check("midrst_idle", 32'(busy), 32'd0);
      clear();
      drive(1'b1, 5);
      drive(1'b0, 14);
      check("midrst_single_edge", 32'(e_single), 32'd16);
      check("midrst_single_count", 32'(n_single), 32'd1);

      check("one_hot_events", 32'(n_multi), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
